insn_fetch: RTL and testbench

//  Instruction fetch stage, directly upstream of insn_decoder: drives the top-level `word` input.

---
 rtl/insn_fetch_pkg.sv | 29 ++
 rtl/insn_fetch_fifo.sv | 83 ++++++++
 rtl/insn_fetch.sv | 174 +++++++++++++++++
 tb/tb_insn_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/insn_fetch_pkg.sv
// rtl/insn_fetch_pkg.sv - shared constants, FSM encoding and address helper for insn_fetch
//
// Purpose : common definitions for the fetch stage and its prefetch FIFO.
// Contents: ADDR_W        fetch address / instruction word width
//           NOP_WORD_DEF  default word shown to the decoder while nothing is fetched
//           if_state_t    fetch FSM encoding (IF_IDLE, IF_REQ, IF_DRAIN)
//           next_addr()   sequential fetch address, wraps modulo 2**ADDR_W

package insn_fetch_pkg;

    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_REQ   = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_t;

    // Plain modulo-2^32 addition: 32'hFFFFFFFF + 1 rolls over to 0 with no flag.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] step
    );
        return addr + step;
    endfunction

endpackage

// File: rtl/insn_fetch_fifo.sv
// rtl/insn_fetch_fifo.sv - prefetch FIFO holding fetched instruction words
//
// Purpose : synchronous DEPTH x WIDTH FIFO, asynchronously reset pointers/count.
//           The head entry is read straight from the storage registers, so a word
//           written on edge N is visible on dout right after edge N.
// Ports   : clk    in   clock
//           rst    in   asynchronous active-high reset
//           push   in   write din this cycle
//           pop    in   drop head entry this cycle (ignored when empty)
//           clear  in   empty the FIFO; wins over push and pop
//           din    in   WIDTH write data
//           dout   out  WIDTH head entry (undefined content when empty)
//           count  out  occupancy, 0..DEPTH
//           empty  out  count == 0
//           full   out  count == DEPTH

module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = pop && (r_count != '0);
    // A write into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed through a valid count.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/insn_fetch.sv
// rtl/insn_fetch.sv - instruction fetch stage feeding the instruction decoder
//
// Purpose : issues sequential word reads to instruction memory over a req/ack
//           handshake, buffers returned words in a prefetch FIFO and redirects
//           on a non-sequential PC write (flush).
// Config  : IF_BYPASS_EN - when defined, a word acked while the FIFO is empty is
//           shown to the decoder combinationally in the ack cycle.
// Ports   : clk         in   clock, all state on posedge
//           rst         in   asynchronous active-high reset
//           flush       in   non-sequential PC write this cycle
//           flush_pc    in   32  new fetch address, valid with flush
//           pcincr      in   decoder consumed the head word
//           imem_addr   out  32  fetch address, valid while imem_req
//           imem_req    out  read request, held until imem_ack
//           imem_ack    in   read data valid this cycle, ends the request
//           imem_rdata  in   32  read data
//           word        out  32  instruction to decoder (FIFO head or NOP_WORD)
//           word_valid  out  word is a real fetched instruction

module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] ADDR_STEP = 32'd1,
    parameter logic [ADDR_W-1:0] NOP_WORD  = NOP_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              pcincr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] word,
    output logic              word_valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    if_state_t         r_state;
    logic [ADDR_W-1:0] r_fa;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;

    logic [ADDR_W-1:0] w_fifo_dout;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_next;
    logic              w_empty;
    logic              w_full;
    logic              w_live_ack;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_room;
    logic [ADDR_W-1:0] w_fa_inc;

    // Only an ack for a request that will be kept counts; acks while draining
    // belong to a fetch that a flush already made stale.
    assign w_live_ack = imem_ack && (r_state == IF_REQ);

    // flush beats pcincr: the head is thrown away with the rest of the FIFO.
    assign w_pop = pcincr && !w_empty && !flush;

`ifdef IF_BYPASS_EN
    assign w_bypass = w_empty && w_live_ack && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that the decoder takes in the same cycle never enters the FIFO.
    assign w_push = w_live_ack && !flush && !(w_bypass && pcincr) && (!w_full || w_pop);

    // Occupancy after this edge; pop needs a non-empty FIFO, so no underflow.
    assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

    // A new request reserves one slot, so it is only issued while a slot is spare.
    assign w_room = (w_count_next < CW'(DEPTH));

    assign w_fa_inc = next_addr(r_fa, ADDR_STEP);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .clear (flush),
        .din   (imem_rdata),
        .dout  (w_fifo_dout),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    // r_fa is the address of the outstanding request while in IF_REQ and the
    // next address to fetch otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IF_IDLE;
            r_fa    <= '0;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IF_IDLE: begin
                    if (flush) begin
                        r_fa <= flush_pc;
                    end else if (w_room) begin
                        r_req   <= 1'b1;
                        r_addr  <= r_fa;
                        r_state <= IF_REQ;
                    end
                end

                IF_REQ: begin
                    if (flush) begin
                        r_fa <= flush_pc;
                        if (imem_ack) begin
                            r_req   <= 1'b0;
                            r_state <= IF_IDLE;
                        end else begin
                            // Memory still owes us a word; keep asking and drop it on arrival.
                            r_state <= IF_DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_fa <= w_fa_inc;
                        if (w_room) begin
                            // Back-to-back request keeps a zero-wait memory at one word per cycle.
                            r_addr <= w_fa_inc;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= IF_IDLE;
                        end
                    end
                end

                IF_DRAIN: begin
                    if (flush) begin
                        r_fa <= flush_pc;
                    end
                    if (imem_ack) begin
                        r_req   <= 1'b0;
                        r_state <= IF_IDLE;
                    end
                end

                default: begin
                    r_req   <= 1'b0;
                    r_state <= IF_IDLE;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;

    always_comb begin
        word       = NOP_WORD;
        word_valid = 1'b0;
        if (w_bypass) begin
            word       = imem_rdata;
            word_valid = 1'b1;
        end else if (!w_empty) begin
            word       = w_fifo_dout;
            word_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_insn_fetch.sv
// tb/tb_insn_fetch.sv - self-checking bench for insn_fetch

module tb_insn_fetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] flush_pc;
    logic        pcincr;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] word;
    logic        word_valid;

    insn_fetch #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .pcincr     (pcincr),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .word       (word),
        .word_valid (word_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: words the decoder should see, in order, plus fetch pointer.
    logic [31:0] q[$];
    logic [31:0] m_fa;
    bit          m_drain;
    bit          p_req, p_ack;
    logic [31:0] p_addr;
    int          n_acks;
    bit          got_first;
    logic [31:0] first_word;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fa      = 32'h0;
        m_drain   = 1'b0;
        p_req     = 1'b0;
        p_ack     = 1'b0;
        p_addr    = 32'h0;
        got_first = 1'b0;
        first_word = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        pcincr = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: entered and left at posedge+1.
    task automatic cyc(input bit ack_en, input bit pc, input bit fl, input logic [31:0] fpc);
        logic        r;
        logic [31:0] a, d, ew;
        bit          ack, ev, byp;
        r = imem_req;
        a = imem_addr;
        if (p_req && !p_ack) begin
            chk("hold_req", r, 1'b1);
            chk("hold_addr", a, p_addr);
        end else if (r && !m_drain) begin
            chk("req_addr", a, m_fa);
        end
        ack = ack_en && r;
        d   = ack ? memf(a) : $urandom;
        imem_ack = ack; imem_rdata = d; pcincr = pc; flush = fl; flush_pc = fpc;
        #1;
        ev = 1'b0; ew = NOP;
        if (q.size() > 0) begin
            ev = 1'b1; ew = q[0];
        end
`ifdef IF_BYPASS_EN
        else if (ack && !m_drain && !fl) begin
            ev = 1'b1; ew = d;
        end
`endif
        chk("word_valid", word_valid, ev);
        chk("word", word, ew);
        if (r && !m_drain) chk("occupancy", q.size() < DEPTH, 1'b1);
        if (word_valid && !got_first && !fl) begin
            got_first = 1'b1; first_word = word;
        end
        @(posedge clk);
        if (ack) n_acks++;
        byp = 1'b0;
        if (fl) begin
            q.delete();
            m_fa = fpc;
            got_first = 1'b0;
            if (r && !ack) m_drain = 1'b1;
            else if (ack) m_drain = 1'b0;
        end else if (ack && m_drain) begin
            m_drain = 1'b0;
        end else begin
`ifdef IF_BYPASS_EN
            byp = (q.size() == 0) && ack && pc;
`endif
            if (pc && q.size() > 0) void'(q.pop_front());
            if (ack && !byp) q.push_back(d);
            if (ack) m_fa = m_fa + 32'd1;
        end
        p_req = r; p_ack = ack; p_addr = a;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nvalid;
        // Reset state
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        pcincr = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_word", word, NOP);
        chk("rst_valid", word_valid, 1'b0);

        // 1: reset asserted mid-request, acks during reset ignored
        do_reset();
        cyc(0, 0, 0, 0);
        chk("t1_req_pre", imem_req, 1'b1);
        #1;
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_req", imem_req, 1'b0);
        chk("t1_word", word, NOP);
        chk("t1_valid", word_valid, 1'b0);
        @(posedge clk); #1;
        chk("t1_req_held", imem_req, 1'b0);
        chk("t1_valid_held", word_valid, 1'b0);
        chk("t1_addr_held", imem_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; imem_ack = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);

        // 2: zero-wait streaming with pcincr every cycle
        do_reset();
        nvalid = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1, 1, 0, 0);
            if (i >= 4 && word_valid) nvalid++;
        end
        chk("t2_stream_rate", nvalid, 10);
        chk("t2_addr", imem_addr, 32'd13);

        // 3: stall with full FIFO, then one pop re-opens fetch
        do_reset();
        n_acks = 0;
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
        chk("t3_acks", n_acks, 4);
        chk("t3_req_idle", imem_req, 1'b0);
        cyc(1, 1, 0, 0);
        chk("t3_refill_req", imem_req, 1'b1);
        chk("t3_refill_addr", imem_addr, 32'd4);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);

        // 4: flush while request outstanding, ack 3 cycles later is dropped
        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h100);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t4_drop_valid", word_valid, 1'b0);
        got_first = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0);
        chk("t4_got_first", got_first, 1'b1);
        chk("t4_first_word", first_word, memf(32'h100));

        // 5: pcincr on empty FIFO, then flush+pcincr together
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 32'h40);
        cyc(1, 0, 0, 0);
        chk("t5_flush_valid", word_valid, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);

        // 6: fetch address wraps from FFFFFFFF to 0
        do_reset();
        cyc(0, 0, 1, 32'hFFFF_FFFF);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("t6_wrap_req", imem_req, 1'b1);
        chk("t6_wrap_addr", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);

        // Randomized mix of stalls, pops and flushes
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] fpc;
            fpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - $urandom_range(0, 2)) : $urandom;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 19) == 0, fpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
